bus_rr_scheduler: RTL and testbench
===================================

Name: bus_rr_scheduler

Overview:
- Single-bus scheduler. Shares one packet bus among `drvrs` device FIFOs using round-robin arbitration.
- Pops one packet from the granted device and pushes it to the device addressed in the packet header, or to all other devices on broadcast.
- Sits between the per-device FIFO front ends (pndng/pop/D_pop) and the receive side (push/D_push).
- Same packet format as the bus generator/arbiter: destination ID in the top 8 bits.

Parameters:
- drvrs, 4, number of devices on the bus (2..16).
- pckg_sz, 16, packet width in bits (>= 9); bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- broadcast, 8'hFF, destination ID meaning "all devices except the source".

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- pndng, in, drvrs, bit i high = device i FIFO non-empty; FIFO is show-ahead.
- D_pop, in, drvrs*pckg_sz, head packet of device i at [i*pckg_sz +: pckg_sz].
- pop, out, drvrs, one-hot one-cycle pop strobe to the granted FIFO.
- push, out, drvrs, push strobe per destination device.
- D_push, out, pckg_sz, packet broadcast to all receivers; valid while any push bit is high.
- busy, out, 1, high in any state other than IDLE.
- grant_id, out, 8, index of the device currently granted.
- pkt_cnt, out, 16, packets delivered; saturates at 16'hFFFF.
- drop_cnt, out, 16, packets dropped; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - pop, push, D_push, busy, grant_id, pkt_cnt, drop_cnt all 0.
  - State = IDLE.
  - Round-robin pointer last = drvrs-1, so device 0 has first priority.
  - A reset mid-transfer aborts it: no pop/push is issued afterwards for that packet.
- All outputs are registered.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If pndng == 0: stay in IDLE.
  - Otherwise: g = first set bit of pndng searching last+1, last+2, ... (wrapping modulo drvrs).
  - Latch pkt <= D_pop[g], grant_id <= g, last <= g, busy <= 1; go to XFER.
- XFER, exactly one cycle:
  - pop[g] = 1 and D_push = pkt.
  - Destination decode, id = pkt[pckg_sz-1 -: 8]:
    - id == broadcast: push = all ones except bit g; pkt_cnt += 1.
    - id < drvrs and id != g: push = one-hot(id); pkt_cnt += 1.
    - id == g, or id >= drvrs and id != broadcast: push = 0; drop_cnt += 1. The packet is still popped.
  - Go to GAP.
- GAP, one cycle:
  - pop = 0, push = 0; D_push holds its value; busy = 1.
  - Lets the FIFOs update pndng. Go to IDLE; busy deasserts on entry to IDLE.
- Throughput: one packet per 3 cycles. Latency from pndng rising in IDLE to pop/push = 1 cycle.
- pndng changes after the latch cycle are ignored for the current packet; the transfer completes as latched.
- If pndng[g] is low in XFER, pop[g] is still issued; FIFOs ignore pop when empty.
- Only one pop bit is ever high. pop and push are never high outside XFER.
- Counters saturate and do not wrap. Both counters increment only in XFER, never both in the same transfer.
- drvrs == 2 with broadcast: push has exactly one bit set (the non-source device).

Test Plan:
- Reset then single request: pndng=4'b0001, D_pop[0]=16'h02AB → 1 cycle later pop=4'b0001, push=4'b0100, D_push=16'h02AB; pkt_cnt=1; busy low 3 cycles after the request.
- Round-robin fairness: pndng=4'b1111 held, each FIFO holding distinct packets → grant order 0,1,2,3,0, one grant every 3 cycles; no device granted twice before all four are served.
- Broadcast: device 2 sends 16'hFF55 → push=4'b1011, D_push=16'hFF55, pkt_cnt increments by 1.
- Drops: device 1 sends 16'h0101 (self), then 16'h0711 (ID 7 >= drvrs) → pop[1] pulses twice, push stays 0, drop_cnt=2, pkt_cnt unchanged.
- Async reset mid-operation: reset=0 asserted between clock edges while in XFER → pop/push/busy drop to 0 immediately, counters 0; after release with pndng=4'b0100, device 2 is served first, because the pointer restarts at device 0 and device 2 is the first pending device from there.
- Saturation: force 65536 dropped packets → drop_cnt stays 16'hFFFF after the 65535th drop.

Source files
------------

// File: rtl/bus_rr_scheduler.sv
// Single-bus round-robin scheduler.
// Pops one packet from the granted device FIFO, then sends it to the device
// named in the header, or to every other device on broadcast.
// A transfer takes three cycles: IDLE (grant) -> XFER (pop/push) -> GAP.
module bus_rr_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic [7:0]                 grant_id,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int             IW       = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [IW-1:0]  LAST_DEV = IW'(drvrs - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic [pckg_sz-1:0]   d_push_q, d_push_d;
  logic                 busy_q, busy_d;
  logic [7:0]           grant_q, grant_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  // Per-device head packets, split out of the flat input bus.
  logic [pckg_sz-1:0]   head [drvrs];

  generate
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_head
      assign head[gi] = D_pop[gi*pckg_sz +: pckg_sz];
    end
  endgenerate

  // Round-robin search: first pending device after the last one granted.
  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = last_q;
    for (int k = 0; k < drvrs; k++) begin
      cand = (cand == LAST_DEV) ? '0 : cand + 1'b1;
      if (!found && pndng[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Destination decode of the candidate's head packet.
  logic [pckg_sz-1:0] sel_pkt;
  logic [7:0]         sel_id;
  logic [drvrs-1:0]   sel_onehot;
  logic [drvrs-1:0]   dec_push;
  logic               deliver;
  always_comb begin
    sel_pkt         = head[sel];
    sel_id          = sel_pkt[pckg_sz-1 -: 8];
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
    dec_push        = '0;
    deliver         = 1'b0;
    if (sel_id == broadcast) begin
      dec_push = ~sel_onehot;
      deliver  = 1'b1;
    end else if ((sel_id < 8'(drvrs)) && (sel_id[IW-1:0] != sel)) begin
      dec_push[sel_id[IW-1:0]] = 1'b1;
      deliver                  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a grant always runs XFER then GAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = XFER;
      XFER:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values. Everything for the XFER cycle is computed on the
  // grant edge so pop/push/counters are registered and visible during XFER.
  always_comb begin
    pop_d      = '0;
    push_d     = '0;
    d_push_d   = d_push_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          pop_d    = sel_onehot;
          push_d   = dec_push;
          d_push_d = sel_pkt;
          busy_d   = 1'b1;
          grant_d  = 8'(sel);
          last_d   = sel;
          if (deliver) begin
            if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      XFER:    busy_d = 1'b1;
      GAP:     busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Output and pointer registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= LAST_DEV;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      d_push_q   <= d_push_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler (4 devices, 16-bit packets).
module tb_bus_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] D_push;
  logic        busy;
  logic [7:0]  grant_id;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] d;
    logic [7:0]  g;
  } exp_t;

  exp_t exp_q[$];

  bus_rr_scheduler #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .busy(busy),
    .grant_id(grant_id), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
    else begin
      passed++;
      $display("check %s = %h", name, act);
    end
  endtask

  // Monitor: every pop strobe is one transfer; compare against the queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pop != 4'b0000) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pop actual pop=%b push=%b required none", pop, push);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pop !== e.pop || push !== e.push || D_push !== e.d || grant_id !== e.g)
            $display("FAIL xfer actual pop=%b push=%b D_push=%h grant=%0d required pop=%b push=%b D_push=%h grant=%0d",
                     pop, push, D_push, grant_id, e.pop, e.push, e.d, e.g);
          else begin
            passed++;
            $display("xfer pop=%b push=%b D_push=%h grant=%0d", pop, push, D_push, grant_id);
          end
        end
      end else if (push != 4'b0000) begin
        total++;
        $display("FAIL push_outside_xfer actual push=%b required 0000", push);
      end
    end
  end

  task automatic expect_xfer(input int dev, input logic [15:0] pkt, input logic [3:0] p);
    exp_t e;
    e.pop  = 4'b0001 << dev;
    e.push = p;
    e.d    = pkt;
    e.g    = 8'(dev);
    exp_q.push_back(e);
  endtask

  // One isolated transfer from a single device; busy must be low after 3 edges.
  task automatic send(input int dev, input logic [15:0] pkt, input logic [3:0] p);
    @(negedge clk);
    D_pop[dev*16 +: 16] = pkt;
    pndng = 4'b0001 << dev;
    expect_xfer(dev, pkt, p);
    @(posedge clk); #1;
    pndng = 4'b0000;
    chk("busy_in_xfer", 32'(busy), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    pndng = 4'b0000;
    D_pop = '0;
    repeat (3) @(negedge clk);
    chk("rst_pop",  32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_dpush", 32'(D_push), 32'd0);
    chk("rst_pkt",  32'(pkt_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;

    // Single request from device 0 to device 2.
    send(0, 16'h02AB, 4'b0100);
    chk("single_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Round robin with all pending; pointer is at 0, so order 1,2,3,0,1.
    @(negedge clk);
    D_pop = {16'h0033, 16'h0322, 16'h0211, 16'h0100};
    pndng = 4'b1111;
    expect_xfer(1, 16'h0211, 4'b0100);
    expect_xfer(2, 16'h0322, 4'b1000);
    expect_xfer(3, 16'h0033, 4'b0001);
    expect_xfer(0, 16'h0100, 4'b0010);
    expect_xfer(1, 16'h0211, 4'b0100);
    repeat (13) @(posedge clk);
    #1 pndng = 4'b0000;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rr_busy_idle", 32'(busy), 32'd0);
    chk("rr_pkt_cnt", 32'(pkt_cnt), 32'd6);
    chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // Broadcast from device 2.
    send(2, 16'hFF55, 4'b1011);
    chk("bcast_pkt_cnt", 32'(pkt_cnt), 32'd7);

    // Drops: self-addressed, then out-of-range ID.
    send(1, 16'h0101, 4'b0000);
    send(1, 16'h0711, 4'b0000);
    chk("drop_cnt", 32'(drop_cnt), 32'd2);
    chk("drop_pkt_cnt", 32'(pkt_cnt), 32'd7);

    // Asynchronous reset during XFER of a device-1 packet.
    @(negedge clk);
    D_pop[16 +: 16] = 16'h0300;
    pndng = 4'b0010;
    @(posedge clk); #2;
    reset = 1'b0;
    pndng = 4'b0000;
    #1;
    chk("mid_rst_pop",  32'(pop), 32'd0);
    chk("mid_rst_push", 32'(push), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pkt",  32'(pkt_cnt), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // Pointer restarts at device 0, so device 1 wins before device 2.
    D_pop[16 +: 16] = 16'h0011;
    D_pop[32 +: 16] = 16'h0022;
    pndng = 4'b0110;
    expect_xfer(1, 16'h0011, 4'b0001);
    expect_xfer(2, 16'h0022, 4'b0001);
    repeat (4) @(posedge clk);
    #1 pndng = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_pkt", 32'(pkt_cnt), 32'd2);

    // Saturation: preload counters near the top, then keep pushing.
    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFE;
    #1 release dut.drop_cnt_q;
    send(3, 16'h0933, 4'b0000);
    chk("drop_sat_reach", 32'(drop_cnt), 32'h0000FFFF);
    send(3, 16'h0333, 4'b0000);
    chk("drop_sat_hold", 32'(drop_cnt), 32'h0000FFFF);
    chk("drop_sat_pkt", 32'(pkt_cnt), 32'd2);
    @(negedge clk);
    force dut.pkt_cnt_q = 16'hFFFF;
    #1 release dut.pkt_cnt_q;
    send(0, 16'h0100, 4'b0010);
    chk("pkt_sat_hold", 32'(pkt_cnt), 32'h0000FFFF);

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
